// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with a skid slot: out_data comes straight from the head
// register, and in_ready depends only on the registered state.
module pipe_skid_reg #(
   parameter int unsigned          WIDTH     = 16,
   parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       occupancy
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
   // The producer holds its payload until that edge; ready never depends on valid.
   // The encoding matches the entry count, so occupancy exposes the state directly.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] skid;
   logic             head_load;
   logic             head_from_skid;
   logic             skid_load;
   logic             accept;
   logic             fire;

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign out_data  = head;
   assign occupancy = state;
   assign accept    = in_valid & in_ready;
   assign fire      = out_valid & out_ready;

   always_comb begin
      state_nxt      = state;
      head_load      = 1'b0;
      head_from_skid = 1'b0;
      skid_load      = 1'b0;
      if (flush) begin
         // A flush drops every entry and any same-cycle input; data registers keep their values.
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  head_load = 1'b1;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               if (accept && fire) begin
                  head_load = 1'b1;
               end else if (accept) begin
                  skid_load = 1'b1;
                  state_nxt = FULL;
               end else if (fire) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (fire) begin
                  head_load      = 1'b1;
                  head_from_skid = 1'b1;
                  state_nxt      = ONE;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= EMPTY;
         head  <= RESET_VAL;
         skid  <= RESET_VAL;
      end else begin
         state <= state_nxt;
         if (head_load) begin
            head <= head_from_skid ? skid : in_data;
         end
         if (skid_load) begin
            skid <= in_data;
         end
      end
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 16, payload width in bits (legal 1..64).
REQ-002 Parameter RESET_VAL, default 0, value loaded into both data registers on reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low: sampled only at the rising edge of clk, asserted when 0.
REQ-005 flush  input  1  synchronous clear of all buffered entries.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 in_ready  output  1  block can accept an entry this cycle.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_data  output  WIDTH  head entry payload, driven directly from a register.
REQ-011 out_ready  input  1  downstream consumes the head entry this cycle.
REQ-012 occupancy  output  2  number of held entries (0, 1 or 2).

Function
REQ-013 Storage: one head register (drives out_data) plus one skid register; at most 2 entries held.
REQ-014 States: EMPTY (occupancy 0), ONE (occupancy 1), FULL (occupancy 2).
REQ-015 Accept = in_valid & in_ready; fire = out_valid & out_ready; both are evaluated on the same edge.
REQ-016 in_ready = 1 in EMPTY and ONE, 0 in FULL; it depends on state only (no combinational path from out_ready or in_valid).
REQ-017 out_valid = 1 in ONE and FULL, 0 in EMPTY; occupancy reflects the state encoding.
REQ-018 EMPTY: on accept, head <= in_data and the state goes to ONE; otherwise the state holds.
REQ-019 ONE with accept & fire: head <= in_data and the state stays ONE.
REQ-020 ONE with accept & no fire: skid <= in_data and the state goes to FULL.
REQ-021 ONE with no accept & fire: the state goes to EMPTY and head is unchanged.
REQ-022 ONE with neither accept nor fire: the state holds.
REQ-023 FULL with fire: head <= skid and the state goes to ONE; in_valid is ignored because in_ready = 0.
REQ-024 FULL with no fire: the state holds.
REQ-025 Latency: an accepted entry appears on out_data with out_valid = 1 on the cycle after acceptance when the block was EMPTY; full throughput is 1 entry/cycle.
REQ-026 Order: entries leave in exactly acceptance order, with no loss and no duplication.
REQ-027 Stability: while out_valid = 1 and out_ready = 0, out_data and out_valid do not change.
REQ-028 flush = 1 at an edge: state <= EMPTY, and any same-cycle input is dropped; data registers keep their values; a same-cycle fire still counts as consumed.
REQ-029 Data registers load only as specified above; otherwise they hold.

Reset
REQ-030 rst_n = 0 at an edge: state <= EMPTY, head = skid = RESET_VAL; the cycle after, out_valid = 0, occupancy = 0, in_ready = 1, out_data = RESET_VAL.
REQ-031 Reset has priority over flush, accept and fire; an entry presented during reset is dropped.
REQ-032 Reset asserted mid-operation (ONE or FULL) discards all entries identically to REQ-030.

Verification
REQ-033 Single entry, WIDTH = 16: after reset, in_valid = 1 with in_data = 0x1234 for 1 cycle and out_ready = 1 -> the next cycle shows out_valid = 1, out_data = 0x1234; the cycle after shows out_valid = 0.
REQ-034 Backpressure: out_ready = 0, push 0xA, then 0xB -> occupancy 1 then 2, in_ready = 0, out_data = 0xA held; raise out_ready -> 0xA then 0xB out, in_ready returns to 1 the cycle after the first fire.
REQ-035 Streaming: in_valid = out_ready = 1 continuously with a ramp 0..99 -> out_data 0..99 in order, one per cycle, occupancy stays 1.
REQ-036 Flush: in FULL (0x5, 0x6), assert flush with in_valid = 1 and in_data = 0x7 -> next cycle out_valid = 0, occupancy = 0; 0x7 never appears.
REQ-037 Reset mid-operation: in FULL, drive rst_n = 0 for one edge -> out_valid = 0, in_ready = 1, out_data = RESET_VAL.
REQ-038 Random: random in_valid and out_ready for 10k cycles -> a scoreboard shows order preserved, no loss, no duplication, and REQ-027 holds every cycle.
